// File: rtl/ppu_ri.sv
// ppu_ri: CPU-facing PPU register interface with status flags, OAM port and VRAM access FSM
module ppu_ri #(
  parameter int VRAM_AW = 14
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [2:0]         ri_sel_in,
  input  logic               ri_ncs_in,
  input  logic               ri_r_nw_in,
  input  logic [7:0]         ri_d_in,
  output logic [7:0]         ri_d_out,
  input  logic               vblank_set_in,
  input  logic               vblank_clr_in,
  input  logic               spr0_hit_in,
  input  logic               spr_ovf_in,
  output logic               nmi_n_out,
  output logic [7:0]         ctrl_out,
  output logic [7:0]         mask_out,
  output logic [7:0]         scroll_x_out,
  output logic [7:0]         scroll_y_out,
  output logic [7:0]         oam_a_out,
  output logic [7:0]         oam_d_out,
  output logic               oam_we_out,
  input  logic [7:0]         oam_d_in,
  output logic [VRAM_AW-1:0] vram_a_out,
  output logic [7:0]         vram_d_out,
  output logic               vram_wr_out,
  output logic               vram_rd_out,
  input  logic [7:0]         vram_d_in,
  input  logic               vram_ack_in
);
  typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;
  state_t state_q, state_d;
  logic ncs_q, w_q, w_d, vbl_q, vbl_d, spr0_q, spr0_d, ovf_q, ovf_d, nmi_n_q, nmi_n_d, oam_we_q, oam_we_d;
  logic [7:0] ctrl_q, ctrl_d, mask_q, mask_d, sx_q, sx_d, sy_q, sy_d, oam_a_q, oam_a_d;
  logic [7:0] oam_wd_q, oam_wd_d, buf_q, buf_d, rd_q, rd_d, vram_wd_q, vram_wd_d;
  logic [VRAM_AW-1:0] addr_q, addr_d, vram_a_q, vram_a_d, addr_inc, addr_hi, addr_lo;
  logic [7:0] wr_sel, rd_sel;
  logic acc, v_go;
  assign acc      = ~ri_ncs_in & ncs_q;
  assign wr_sel   = {8{acc & ~ri_r_nw_in}} & (8'd1 << ri_sel_in);
  assign rd_sel   = {8{acc & ri_r_nw_in}} & (8'd1 << ri_sel_in);
  assign v_go     = (wr_sel[7] | rd_sel[7]) & (state_q == IDLE);
  assign addr_inc = addr_q + (ctrl_q[2] ? VRAM_AW'(32) : VRAM_AW'(1));
  assign addr_hi  = (addr_q & ~VRAM_AW'(14'h3f00)) | VRAM_AW'({ri_d_in[5:0], 8'h00});
  assign addr_lo  = (addr_q & ~VRAM_AW'(8'hff)) | VRAM_AW'(ri_d_in);
  always_comb begin
    state_d = (state_q == IDLE) ? (v_go ? (ri_r_nw_in ? READ : WRITE) : IDLE)
                                : (vram_ack_in ? IDLE : state_q);
  end
  always_comb begin
    ctrl_d    = wr_sel[0] ? ri_d_in : ctrl_q;
    mask_d    = wr_sel[1] ? ri_d_in : mask_q;
    sx_d      = (wr_sel[5] && !w_q) ? ri_d_in : sx_q;
    sy_d      = (wr_sel[5] && w_q) ? ri_d_in : sy_q;
    w_d       = rd_sel[2] ? 1'b0 : (wr_sel[5] || wr_sel[6]) ? ~w_q : w_q;
    oam_we_d  = wr_sel[4];
    oam_wd_d  = wr_sel[4] ? ri_d_in : oam_wd_q;
    oam_a_d   = wr_sel[3] ? ri_d_in : oam_we_q ? oam_a_q + 8'd1 : oam_a_q;
    addr_d    = wr_sel[6] ? (w_q ? addr_lo : addr_hi) : v_go ? addr_inc : addr_q;
    vram_a_d  = v_go ? addr_q : vram_a_q;
    vram_wd_d = (v_go && !ri_r_nw_in) ? ri_d_in : vram_wd_q;
    buf_d     = (state_q == READ && vram_ack_in) ? vram_d_in : buf_q;
    rd_d      = rd_sel[2] ? {vbl_q, spr0_q, ovf_q, 5'b0} : rd_sel[4] ? oam_d_in : rd_sel[7] ? buf_q : rd_q;
    vbl_d     = (vblank_clr_in || rd_sel[2]) ? 1'b0 : vblank_set_in ? 1'b1 : vbl_q;
    spr0_d    = vblank_clr_in ? 1'b0 : spr0_hit_in ? 1'b1 : spr0_q;
    ovf_d     = vblank_clr_in ? 1'b0 : spr_ovf_in ? 1'b1 : ovf_q;
    nmi_n_d   = ~(vbl_d & ctrl_d[7]);
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      ncs_q     <= 1'b1;
      w_q       <= 1'b0;
      vbl_q     <= 1'b0;
      spr0_q    <= 1'b0;
      ovf_q     <= 1'b0;
      nmi_n_q   <= 1'b1;
      oam_we_q  <= 1'b0;
      ctrl_q    <= '0;
      mask_q    <= '0;
      sx_q      <= '0;
      sy_q      <= '0;
      oam_a_q   <= '0;
      oam_wd_q  <= '0;
      buf_q     <= '0;
      rd_q      <= '0;
      vram_wd_q <= '0;
      addr_q    <= '0;
      vram_a_q  <= '0;
    end else begin
      state_q   <= state_d;
      ncs_q     <= ri_ncs_in;
      w_q       <= w_d;
      vbl_q     <= vbl_d;
      spr0_q    <= spr0_d;
      ovf_q     <= ovf_d;
      nmi_n_q   <= nmi_n_d;
      oam_we_q  <= oam_we_d;
      ctrl_q    <= ctrl_d;
      mask_q    <= mask_d;
      sx_q      <= sx_d;
      sy_q      <= sy_d;
      oam_a_q   <= oam_a_d;
      oam_wd_q  <= oam_wd_d;
      buf_q     <= buf_d;
      rd_q      <= rd_d;
      vram_wd_q <= vram_wd_d;
      addr_q    <= addr_d;
      vram_a_q  <= vram_a_d;
    end
  end
  assign ri_d_out     = rd_q;
  assign nmi_n_out    = nmi_n_q;
  assign ctrl_out     = ctrl_q;
  assign mask_out     = mask_q;
  assign scroll_x_out = sx_q;
  assign scroll_y_out = sy_q;
  assign oam_a_out    = oam_a_q;
  assign oam_d_out    = oam_wd_q;
  assign oam_we_out   = oam_we_q;
  assign vram_a_out   = vram_a_q;
  assign vram_d_out   = vram_wd_q;
  assign vram_wr_out  = (state_q == WRITE);
  assign vram_rd_out  = (state_q == READ);
endmodule

// File: tb/tb_ppu_ri.sv
// tb_ppu_ri: randomized self-checking bench for ppu_ri against a transaction-level model
module tb_ppu_ri;
  localparam int AW = 14;
  logic clk = 1'b0, rst = 1'b0;
  logic [2:0] ri_sel_in = '0;
  logic ri_ncs_in = 1'b1, ri_r_nw_in = 1'b1;
  logic [7:0] ri_d_in = '0, ri_d_out;
  logic vblank_set_in = 1'b0, vblank_clr_in = 1'b0, spr0_hit_in = 1'b0, spr_ovf_in = 1'b0;
  logic nmi_n_out;
  logic [7:0] ctrl_out, mask_out, scroll_x_out, scroll_y_out, oam_a_out, oam_d_out, oam_d_in;
  logic oam_we_out;
  logic [AW-1:0] vram_a_out;
  logic [7:0] vram_d_out, vram_d_in = '0;
  logic vram_wr_out, vram_rd_out, vram_ack_in = 1'b0;
  int n_chk = 0, n_fail = 0;
  int ack_lat = 1, ack_cnt = 0;
  logic [7:0] vmem [0:16383];
  logic [7:0] omem [0:255];
  logic [7:0] m_ctrl, m_mask, m_sx, m_sy, m_oam, m_buf, m_rd;
  logic [AW-1:0] m_addr, m_va;
  logic m_w, m_vbl, m_spr0, m_ovf;

  ppu_ri #(.VRAM_AW(AW)) dut (
    .clk(clk), .rst(rst), .ri_sel_in(ri_sel_in), .ri_ncs_in(ri_ncs_in), .ri_r_nw_in(ri_r_nw_in),
    .ri_d_in(ri_d_in), .ri_d_out(ri_d_out), .vblank_set_in(vblank_set_in), .vblank_clr_in(vblank_clr_in),
    .spr0_hit_in(spr0_hit_in), .spr_ovf_in(spr_ovf_in), .nmi_n_out(nmi_n_out), .ctrl_out(ctrl_out),
    .mask_out(mask_out), .scroll_x_out(scroll_x_out), .scroll_y_out(scroll_y_out), .oam_a_out(oam_a_out),
    .oam_d_out(oam_d_out), .oam_we_out(oam_we_out), .oam_d_in(oam_d_in), .vram_a_out(vram_a_out),
    .vram_d_out(vram_d_out), .vram_wr_out(vram_wr_out), .vram_rd_out(vram_rd_out), .vram_d_in(vram_d_in),
    .vram_ack_in(vram_ack_in)
  );

  always #5 clk = ~clk;
  assign oam_d_in = omem[oam_a_out];

  // VRAM responder: acks a pending request after ack_lat idle cycles
  always @(negedge clk) begin
    if ((vram_rd_out || vram_wr_out) && !vram_ack_in) begin
      if (ack_cnt >= ack_lat) begin
        vram_ack_in = 1'b1;
        if (vram_wr_out) vmem[vram_a_out] = vram_d_out;
        else vram_d_in = vmem[vram_a_out];
      end else ack_cnt++;
    end else begin
      vram_ack_in = 1'b0;
      ack_cnt = 0;
      vram_d_in = 8'($urandom);
    end
  end

  task automatic m_zero();
    {m_ctrl, m_mask, m_sx, m_sy, m_oam, m_buf, m_rd} = '0;
    m_addr = '0; m_va = '0;
    {m_w, m_vbl, m_spr0, m_ovf} = '0;
  endtask

  task automatic m_access(input logic [2:0] sel, input logic rnw, input logic [7:0] d);
    if (sel == 3'd7) begin
      m_va = m_addr;
      if (rnw) begin m_rd = m_buf; m_buf = vmem[m_addr]; end
      m_addr = m_addr + (m_ctrl[2] ? AW'(32) : AW'(1));
    end else if (rnw) begin
      if (sel == 3'd2) begin m_rd = {m_vbl, m_spr0, m_ovf, 5'b0}; m_vbl = 1'b0; m_w = 1'b0; end
      else if (sel == 3'd4) m_rd = omem[m_oam];
    end else begin
      case (sel)
        3'd0: m_ctrl = d;
        3'd1: m_mask = d;
        3'd3: m_oam = d;
        3'd4: m_oam = m_oam + 8'd1;
        3'd5: begin if (m_w) m_sy = d; else m_sx = d; m_w = ~m_w; end
        3'd6: begin if (m_w) m_addr[7:0] = d; else m_addr = {d[5:0], m_addr[7:0]}; m_w = ~m_w; end
        default: ;
      endcase
    end
  endtask

  task automatic acc(input logic [2:0] sel, input logic rnw, input logic [7:0] d, input int len);
    @(negedge clk);
    ri_sel_in = sel; ri_r_nw_in = rnw; ri_d_in = d; ri_ncs_in = 1'b0;
    repeat (len) @(negedge clk);
    ri_ncs_in = 1'b1; ri_d_in = 8'($urandom);
    @(negedge clk);
  endtask

  task automatic acc_m(input logic [2:0] sel, input logic rnw, input logic [7:0] d, input int len);
    m_access(sel, rnw, d);
    acc(sel, rnw, d, len);
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((vram_rd_out || vram_wr_out) && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) begin
      n_fail++;
      $display("FAIL vram_timeout: request still pending after %0d cycles, required completion", k);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0; ri_ncs_in = 1'b1;
    {vblank_set_in, vblank_clr_in, spr0_hit_in, spr_ovf_in} = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_zero();
  endtask

  task automatic pulse(input logic vs, input logic vc, input logic s0, input logic ov);
    @(negedge clk);
    {vblank_set_in, vblank_clr_in, spr0_hit_in, spr_ovf_in} = {vs, vc, s0, ov};
    @(negedge clk);
    {vblank_set_in, vblank_clr_in, spr0_hit_in, spr_ovf_in} = '0;
    if (vc) {m_vbl, m_spr0, m_ovf} = '0;
    else begin m_vbl |= vs; m_spr0 |= s0; m_ovf |= ov; end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_chk++; if (ri_d_out !== 8'h00) begin n_fail++; $display("FAIL reset_rd: got %h want 00", ri_d_out); end
    n_chk++; if (nmi_n_out !== 1'b1) begin n_fail++; $display("FAIL reset_nmi: got %b want 1", nmi_n_out); end
    n_chk++; if ({ctrl_out, mask_out, scroll_x_out, scroll_y_out} !== 32'h0) begin
      n_fail++; $display("FAIL reset_regs: got %h%h%h%h want 0", ctrl_out, mask_out, scroll_x_out, scroll_y_out); end
    n_chk++; if (oam_a_out !== 8'h00 || oam_we_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_oam: got a=%h we=%b want a=00 we=0", oam_a_out, oam_we_out); end
    n_chk++; if (vram_wr_out !== 1'b0 || vram_rd_out !== 1'b0 || vram_a_out !== '0) begin
      n_fail++; $display("FAIL reset_vram: got wr=%b rd=%b a=%h want 0", vram_wr_out, vram_rd_out, vram_a_out); end
  endtask

  task automatic test_regs_random();
    for (int i = 0; i < 40; i++) begin
      logic [2:0] sel = 3'($urandom_range(0, 6));
      logic rnw = 1'($urandom);
      acc_m(sel, rnw, 8'($urandom), $urandom_range(1, 4));
      n_chk++;
      if ({ctrl_out, mask_out, scroll_x_out, scroll_y_out} !== {m_ctrl, m_mask, m_sx, m_sy}) begin
        n_fail++;
        $display("FAIL regs[%0d] sel=%0d rnw=%b: got %h %h %h %h want %h %h %h %h", i, sel, rnw,
                 ctrl_out, mask_out, scroll_x_out, scroll_y_out, m_ctrl, m_mask, m_sx, m_sy);
      end
      n_chk++; if (oam_a_out !== m_oam) begin n_fail++; $display("FAIL oamaddr[%0d]: got %h want %h", i, oam_a_out, m_oam); end
      n_chk++; if (ri_d_out !== m_rd) begin n_fail++; $display("FAIL rdata[%0d] sel=%0d rnw=%b: got %h want %h", i, sel, rnw, ri_d_out, m_rd); end
    end
  endtask

  task automatic test_vram_write();
    int k = 0;
    logic ok = 1'b1;
    ack_lat = 4;
    acc_m(0, 0, 8'h00, 1);
    acc_m(2, 1, 8'h00, 1);
    acc_m(6, 0, 8'h21, 1);
    acc_m(6, 0, 8'h08, 2);
    m_access(7, 0, 8'h55);
    acc(7, 0, 8'h55, 1);
    n_chk++;
    if (vram_wr_out !== 1'b1 || vram_a_out !== 14'h2108 || vram_d_out !== 8'h55) begin
      n_fail++; $display("FAIL vwr_req: got wr=%b a=%h d=%h want 1 2108 55", vram_wr_out, vram_a_out, vram_d_out);
    end
    while (vram_wr_out && k < 50) begin
      if (vram_a_out !== 14'h2108 || vram_d_out !== 8'h55) ok = 1'b0;
      @(negedge clk); k++;
    end
    n_chk++; if (!ok || k >= 50) begin n_fail++; $display("FAIL vwr_hold: stable=%b cycles=%0d want stable until ack", ok, k); end
    n_chk++; if (vmem[14'h2108] !== 8'h55) begin n_fail++; $display("FAIL vwr_data: got %h want 55", vmem[14'h2108]); end
    acc_m(7, 1, 8'h00, 1);
    wait_idle();
    n_chk++; if (vram_a_out !== 14'h2109) begin n_fail++; $display("FAIL vwr_inc: got %h want 2109", vram_a_out); end
    n_chk++; if (ri_d_out !== m_rd) begin n_fail++; $display("FAIL vwr_rd: got %h want %h", ri_d_out, m_rd); end
  endtask

  task automatic test_vram_read();
    logic [7:0] exp;
    do_reset();
    ack_lat = 2;
    vmem[14'h3ff0] = 8'($urandom_range(1, 255));
    exp = vmem[14'h3ff0];
    acc_m(0, 0, 8'h04, 1);
    acc_m(6, 0, 8'h3f, 1);
    acc_m(6, 0, 8'hf0, 1);
    acc_m(7, 1, 8'h00, 1);
    wait_idle();
    n_chk++; if (ri_d_out !== 8'h00) begin n_fail++; $display("FAIL vrd_first: got %h want 00", ri_d_out); end
    acc_m(7, 1, 8'h00, 3);
    wait_idle();
    n_chk++; if (ri_d_out !== exp) begin n_fail++; $display("FAIL vrd_second: got %h want %h", ri_d_out, exp); end
    n_chk++; if (vram_a_out !== 14'h0010) begin n_fail++; $display("FAIL vrd_wrap: got %h want 0010", vram_a_out); end
    acc_m(7, 1, 8'h00, 1);
    wait_idle();
    n_chk++; if (vram_a_out !== 14'h0030) begin n_fail++; $display("FAIL vrd_addr: got %h want 0030", vram_a_out); end
  endtask

  task automatic test_vram_random();
    for (int i = 0; i < 30; i++) begin
      logic rnw = 1'($urandom);
      logic [7:0] d = 8'($urandom);
      ack_lat = $urandom_range(0, 3);
      if (i % 7 == 0) acc_m(0, 0, {5'b0, 1'($urandom), 2'b0}, 1);
      if (i % 5 == 0) begin
        acc_m(6, 0, 8'($urandom), 1);
        acc_m(6, 0, 8'($urandom), 1);
      end
      acc_m(7, rnw, d, $urandom_range(1, 3));
      wait_idle();
      n_chk++; if (vram_a_out !== m_va) begin n_fail++; $display("FAIL vrand_a[%0d]: got %h want %h", i, vram_a_out, m_va); end
      n_chk++;
      if (rnw ? (ri_d_out !== m_rd) : (vmem[m_va] !== d)) begin
        n_fail++; $display("FAIL vrand_d[%0d] rnw=%b: got rd=%h mem=%h want rd=%h mem=%h", i, rnw, ri_d_out, vmem[m_va], m_rd, d);
      end
    end
  endtask

  task automatic test_busy_drop();
    logic [7:0] old_buf;
    logic [AW-1:0] a0;
    ack_lat = 12;
    old_buf = m_buf;
    a0 = m_addr;
    acc_m(7, 1, 8'h00, 1);
    acc(7, 1, 8'h00, 1);
    n_chk++; if (ri_d_out !== old_buf || vram_a_out !== a0 || vram_rd_out !== 1'b1) begin
      n_fail++; $display("FAIL busy_read: got d=%h a=%h rd=%b want d=%h a=%h rd=1", ri_d_out, vram_a_out, vram_rd_out, old_buf, a0);
    end
    acc(7, 0, 8'h77, 1);
    n_chk++; if (vram_wr_out !== 1'b0 || vram_a_out !== a0) begin
      n_fail++; $display("FAIL busy_write: got wr=%b a=%h want wr=0 a=%h", vram_wr_out, vram_a_out, a0);
    end
    wait_idle();
    ack_lat = 1;
    acc_m(7, 1, 8'h00, 1);
    wait_idle();
    n_chk++; if (vram_a_out !== m_va || ri_d_out !== m_rd) begin
      n_fail++; $display("FAIL busy_after: got a=%h d=%h want a=%h d=%h", vram_a_out, ri_d_out, m_va, m_rd);
    end
  endtask

  task automatic test_nmi();
    do_reset();
    pulse(1, 0, 0, 0);
    n_chk++; if (nmi_n_out !== 1'b1) begin n_fail++; $display("FAIL nmi_off: got %b want 1", nmi_n_out); end
    @(negedge clk);
    ri_sel_in = 3'd0; ri_r_nw_in = 1'b0; ri_d_in = 8'h80; ri_ncs_in = 1'b0;
    m_access(0, 0, 8'h80);
    @(negedge clk);
    n_chk++; if (nmi_n_out !== 1'b0) begin n_fail++; $display("FAIL nmi_on: got %b want 0", nmi_n_out); end
    ri_ncs_in = 1'b1;
    @(negedge clk);
    acc_m(5, 0, 8'h11, 1);
    @(negedge clk);
    ri_sel_in = 3'd2; ri_r_nw_in = 1'b1; ri_ncs_in = 1'b0;
    m_access(2, 1, 8'h00);
    @(negedge clk);
    n_chk++; if (ri_d_out !== 8'h80 || nmi_n_out !== 1'b1) begin
      n_fail++; $display("FAIL nmi_status: got d=%h nmi=%b want d=80 nmi=1", ri_d_out, nmi_n_out);
    end
    ri_ncs_in = 1'b1;
    @(negedge clk);
    acc_m(5, 0, 8'h22, 1);
    n_chk++; if (scroll_x_out !== 8'h22 || scroll_y_out !== 8'h00) begin
      n_fail++; $display("FAIL nmi_wclr: got x=%h y=%h want x=22 y=00", scroll_x_out, scroll_y_out);
    end
  endtask

  task automatic test_status_race();
    logic ok = 1'b1;
    @(negedge clk);
    ri_sel_in = 3'd2; ri_r_nw_in = 1'b1; ri_ncs_in = 1'b0; vblank_set_in = 1'b1;
    @(negedge clk);
    vblank_set_in = 1'b0;
    n_chk++; if (ri_d_out !== 8'h00) begin n_fail++; $display("FAIL race_rd: got %h want 00", ri_d_out); end
    ri_ncs_in = 1'b1;
    repeat (4) begin if (nmi_n_out !== 1'b1) ok = 1'b0; @(negedge clk); end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL race_nmi: nmi asserted, want 1 throughout"); end
    acc_m(2, 1, 8'h00, 1);
    n_chk++; if (ri_d_out !== 8'h00) begin n_fail++; $display("FAIL race_vbl: got %h want 00", ri_d_out); end
  endtask

  task automatic test_flags();
    acc_m(0, 0, 8'($urandom), 1);
    for (int i = 0; i < 24; i++) begin
      pulse(1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom));
      n_chk++; if (nmi_n_out !== ~(m_vbl & m_ctrl[7])) begin
        n_fail++; $display("FAIL flag_nmi[%0d]: got %b want %b", i, nmi_n_out, ~(m_vbl & m_ctrl[7]));
      end
      if (i % 3 == 2) begin
        acc_m(2, 1, 8'h00, $urandom_range(1, 3));
        n_chk++; if (ri_d_out !== m_rd) begin n_fail++; $display("FAIL flag_status[%0d]: got %h want %h", i, ri_d_out, m_rd); end
      end
    end
  endtask

  task automatic test_oam();
    int cnt = 0;
    logic [7:0] pa = '0, pd = '0;
    acc_m(3, 0, 8'hff, 1);
    @(negedge clk);
    ri_sel_in = 3'd4; ri_r_nw_in = 1'b0; ri_d_in = 8'haa; ri_ncs_in = 1'b0;
    m_access(4, 0, 8'haa);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i == 4) ri_ncs_in = 1'b1;
      if (oam_we_out) begin cnt++; pa = oam_a_out; pd = oam_d_out; end
    end
    n_chk++; if (cnt != 1 || pa !== 8'hff || pd !== 8'haa) begin
      n_fail++; $display("FAIL oam_we: got pulses=%0d a=%h d=%h want 1 ff aa", cnt, pa, pd);
    end
    n_chk++; if (oam_a_out !== 8'h00) begin n_fail++; $display("FAIL oam_wrap: got %h want 00", oam_a_out); end
    acc_m(3, 0, 8'($urandom), 1);
    acc_m(4, 1, 8'h00, 3);
    n_chk++; if (ri_d_out !== m_rd || oam_a_out !== m_oam) begin
      n_fail++; $display("FAIL oam_read: got d=%h a=%h want d=%h a=%h", ri_d_out, oam_a_out, m_rd, m_oam);
    end
  endtask

  task automatic test_reset_midread();
    acc_m(0, 0, 8'h84, 1);
    acc_m(1, 0, 8'h1e, 1);
    ack_lat = 50;
    acc_m(7, 1, 8'h00, 1);
    n_chk++; if (vram_rd_out !== 1'b1) begin n_fail++; $display("FAIL rstrd_req: got %b want 1", vram_rd_out); end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if (vram_rd_out !== 1'b0 || vram_wr_out !== 1'b0 || ctrl_out !== 8'h00 || mask_out !== 8'h00 ||
        nmi_n_out !== 1'b1 || ri_d_out !== 8'h00 || vram_a_out !== '0 || oam_a_out !== 8'h00) begin
      n_fail++;
      $display("FAIL rstrd_state: got rd=%b wr=%b ctrl=%h mask=%h nmi=%b d=%h a=%h oam=%h want reset values",
               vram_rd_out, vram_wr_out, ctrl_out, mask_out, nmi_n_out, ri_d_out, vram_a_out, oam_a_out);
    end
    rst = 1'b1;
    m_zero();
    ack_lat = 1;
    repeat (3) @(negedge clk);
    n_chk++; if (vram_rd_out !== 1'b0) begin n_fail++; $display("FAIL rstrd_idle: got %b want 0", vram_rd_out); end
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) vmem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) omem[i] = 8'($urandom);
    m_zero();
    test_reset();
    test_regs_random();
    test_vram_write();
    test_vram_read();
    test_vram_random();
    test_busy_drop();
    test_nmi();
    test_status_race();
    test_flags();
    test_oam();
    test_reset_midread();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/ppu_ri.md
PPU_RI -- requirements
Module: ppu_ri

Interface
REQ-001 SHALL have parameter: VRAM_AW, default 14, VRAM address width in bits.
REQ-002 SHALL have port: clk  input  1  system clock; all logic sampled on rising edge.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-low.
REQ-004 SHALL have ports: ri_sel_in  input  3  register select; ri_ncs_in  input  1  chip select, active-low; ri_r_nw_in  input  1  1=read, 0=write; ri_d_in  input  8  CPU write data.
REQ-005 SHALL have port: ri_d_out  output  8  CPU read data, registered.
REQ-006 SHALL have ports: vblank_set_in, vblank_clr_in, spr0_hit_in, spr_ovf_in  input  1 each  single-cycle status pulses from the render pipeline.
REQ-007 SHALL have ports: nmi_n_out  output  1  NMI, active-low; ctrl_out, mask_out, scroll_x_out, scroll_y_out  output  8 each  register contents.
REQ-008 SHALL have ports: oam_a_out  output  8  OAM address (= OAMADDR); oam_d_out  output  8  OAM write data; oam_we_out  output  1  OAM write strobe; oam_d_in  input  8  OAM read data, valid combinationally for oam_a_out.
REQ-009 SHALL have ports: vram_a_out  output  VRAM_AW  VRAM address; vram_d_out  output  8  write data; vram_wr_out, vram_rd_out  output  1 each  requests; vram_d_in  input  8  read data; vram_ack_in  input  1  request completion.

Function
REQ-010 SHALL detect an access on the first cycle ri_ncs_in is low after being high in the previous cycle (registered copy); exactly one action per chip-select assertion regardless of its length.
REQ-011 SHALL keep a write toggle w; w flips on each PPUSCROLL/PPUADDR write and clears on PPUSTATUS read.
REQ-012 sel 0 write SHALL load ctrl; sel 1 write SHALL load mask; sel 3 write SHALL load OAMADDR.
REQ-013 sel 2 read SHALL return {vbl, spr0, ovf, 5'b0} in ri_d_out next cycle, then clear vbl and w.
REQ-014 sel 4 write SHALL pulse oam_we_out one cycle with oam_d_out=data at current OAMADDR, then OAMADDR+1 (255 wraps to 0); sel 4 read SHALL return oam_d_in without incrementing.
REQ-015 sel 5 write SHALL load scroll_x when w=0, scroll_y when w=1.
REQ-016 sel 6 write SHALL load addr[13:8]<=d[5:0] when w=0 and addr[7:0]<=d when w=1.
REQ-017 sel 7 access SHALL latch addr into vram_a_out, then increment addr by 32 if ctrl[2] else 1, modulo 2^VRAM_AW.
REQ-018 sel 7 read SHALL return the current read buffer and launch a VRAM read that refills the buffer; no palette bypass.
REQ-019 VRAM FSM SHALL have states IDLE, WRITE, READ: IDLE->WRITE/READ on sel 7 access; request held with stable address/data until vram_ack_in=1; on ack READ captures vram_d_in into buffer; both return to IDLE the cycle after ack.
REQ-020 a sel 7 access while FSM not IDLE SHALL be dropped: no request, no increment, read returns unchanged buffer.
REQ-021 Writes to sel 2 and reads of write-only registers SHALL have no side effect; ri_d_out SHALL hold its previous value.
REQ-022 vbl SHALL set on vblank_set_in; spr0/ovf SHALL set on their pulses; vblank_clr_in SHALL clear all three; clr wins over any simultaneous set.
REQ-023 PPUSTATUS read coinciding with vblank_set_in SHALL return vbl=0 and leave vbl clear.
REQ-024 nmi_n_out SHALL be registered ~(vbl & ctrl[7]); enabling ctrl[7] while vbl=1 asserts NMI the next cycle.

Reset
REQ-025 rst low at a clock edge SHALL zero ctrl, mask, scroll, OAMADDR, addr, buffer, flags, w, ri_d_out, all strobes/requests, set nmi_n_out=1 and FSM=IDLE, aborting any pending VRAM request.

Verification
REQ-026 Write $06=$21, $06=$08, $07=$55 -> vram_wr_out high at $2108 with $55 held until ack; addr becomes $2109.
REQ-027 ctrl[2]=1, addr=$3FF0, two $07 reads with 2-cycle ack -> first returns $00 (buffer), second returns data of $3FF0; addr becomes $0030 (wrap).
REQ-028 vblank_set_in pulse, ctrl=$80 -> nmi_n_out=0; $02 read -> $80 returned, nmi_n_out=1 next cycle, w=0.
REQ-029 $02 read same cycle as vblank_set_in -> returns $00, vbl stays 0, nmi_n_out stays 1.
REQ-030 OAMADDR=$FF, $04 write $AA held low 5 cycles -> one oam_we_out pulse at $FF, OAMADDR=$00.
REQ-031 rst low during READ waiting for ack -> vram_rd_out=0 next cycle, FSM IDLE, all outputs at reset values.
